// File: rtl/apb_cmd_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns read data / error status on a valid/ready response channel.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 (first APB phase)
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid high until the response handshake
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_slverr_q, rsp_slverr_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  // Saturating increment so a disabled timeout can never wrap the counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES > 0) && (cnt_inc == TO_LIMIT)) begin
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !preset;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of transfers plus reset corner cases.
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .CNT_WIDTH(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          nwait;     // ACCESS cycles with pready=0 before pready=1
    logic [31:0] rdata;
    logic        perr;
    int          hold;      // cycles of rsp_ready=0 in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;   // expected number of ACCESS cycles
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input vec_t v);
    chk({tag, " paddr"}, paddr, v.addr);
    chk({tag, " pwrite"}, 32'(pwrite), 32'(v.wr));
    chk({tag, " pwdata"}, pwdata, v.wdata);
    chk({tag, " pstrb"}, 32'(pstrb), v.wr ? 32'(v.strb) : 32'd0);
    chk({tag, " pprot"}, 32'(pprot), 32'(v.prot));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  acc;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_write = v.wr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    chk({tag, " setup_psel"}, 32'(psel), 32'd1);
    chk({tag, " setup_penable"}, 32'(penable), 32'd0);
    chk({tag, " setup_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk_ctrl({tag, " setup"}, v);
    step();
    acc = 0;
    for (int w = 0; w < 20; w++) begin
      chk({tag, " access_sel_en"}, {30'd0, psel, penable}, 32'd3);
      chk_ctrl({tag, " access"}, v);
      acc++;
      if (w == v.nwait) begin
        pready  = 1'b1;
        prdata  = v.rdata;
        pslverr = v.perr;
      end else begin
        pready  = 1'b0;
        prdata  = 32'hBAD0_0000 | 32'(w);
        pslverr = 1'b1;
      end
      step();
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h5A5A_5A5A;
      if (rsp_valid) break;
    end
    chk({tag, " access_cycles"}, 32'(acc), 32'(v.exp_acc));
    for (int h = 0; h <= v.hold; h++) begin
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, " rsp_err_to"}, {30'd0, rsp_slverr, rsp_timeout}, {30'd0, v.exp_err, v.exp_to});
      chk({tag, " resp_sel_en"}, {30'd0, psel, penable}, 32'd0);
      chk({tag, " resp_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, " resp_paddr_held"}, paddr, v.addr);
      if (h < v.hold) begin
        // A competing command during backpressure must not be taken.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0BAD;
        rsp_ready = 1'b0;
        step();
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, " cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, " psel_after"}, 32'(psel), 32'd0);
  endtask

  initial begin
    //          wr    addr           wdata          strb     prot    nw  rdata          perr hold exp_rdata      err   to    acc
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF,    3'b000, 0,  32'h0,         1'b0, 0, 32'h0,         1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_2000, 32'h1111_2222, 4'hF,    3'b010, 3,  32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_3008, 32'h0,         4'h3,    3'b001, 0,  32'hCAFE_F00D, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_400C, 32'h0,         4'h0,    3'b100, 99, 32'h0,         1'b0, 0, 32'h0,         1'b1, 1'b1, 4};
    vecs[4] = '{1'b1, 32'h0000_5010, 32'hA5A5_0F0F, 4'h9,    3'b011, 99, 32'h0,         1'b0, 0, 32'h0,         1'b1, 1'b1, 4};
    vecs[5] = '{1'b1, 32'h0000_6014, 32'h0BAD_CAFE, 4'hC,    3'b111, 3,  32'h7777_7777, 1'b0, 0, 32'h0,         1'b0, 1'b0, 4};
    vecs[6] = '{1'b1, 32'h0000_7018, 32'h1357_9BDF, 4'b0101, 3'b110, 1,  32'hFFFF_FFFF, 1'b1, 5, 32'h0,         1'b1, 1'b0, 2};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;      // held high early; must have no effect outside RESP
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    step();
    step();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst psel_penable", {30'd0, psel, penable}, 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst paddr", paddr, 32'd0);
    chk("rst pwdata", pwdata, 32'd0);
    chk("rst pstrb_pprot_pwrite", {24'd0, pstrb, pprot, pwrite}, 32'd0);
    chk("rst rsp_fields", rsp_rdata | 32'(rsp_slverr) | 32'(rsp_timeout), 32'd0);
    preset = 1'b0;
    step();
    rsp_ready = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while in ACCESS: transfer is dropped with no response.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_8000;
    cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("midrst in_access", {30'd0, psel, penable}, 32'd3);
    pready = 1'b0;
    preset = 1'b1;
    step();
    chk("midrst psel_penable", {30'd0, psel, penable}, 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    preset = 1'b0;
    #1;
    chk("midrst cmd_ready_rel", 32'(cmd_ready), 32'd1);
    step();
    step();
    chk("midrst no_rsp", 32'(rsp_valid), 32'd0);
    chk("midrst idle_psel", 32'(psel), 32'd0);
    run_vec(7, vecs[1]);
    run_vec(8, vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
